// File: rtl/bp_be_redirect_gen_if.sv
// Handshake/bus bundle between the backend redirect generator and its
// environment: branch resolution, dispatch, trap redirect, frontend command.
interface bp_be_redirect_gen_if #(
    parameter int vaddr_width_p = 39,
    parameter int cnt_width_p   = 16
);
    logic                     br_v_i;
    logic                     br_branch_i;
    logic                     br_btaken_i;
    logic [vaddr_width_p-1:0] br_npc_i;
    logic                     dispatch_v_i;
    logic [vaddr_width_p-1:0] dispatch_pc_i;
    logic                     ext_redirect_v_i;
    logic [vaddr_width_p-1:0] ext_npc_i;
    logic                     poison_o;
    logic                     cmd_v_o;
    logic                     cmd_ready_i;
    logic [vaddr_width_p-1:0] cmd_npc_o;
    logic                     cmd_branch_o;
    logic                     cmd_taken_o;
    logic                     busy_o;
    logic [cnt_width_p-1:0]   mispredict_cnt_o;

    // Environment side: drives resolutions, dispatches, redirects, ready.
    modport master (
        output br_v_i, br_branch_i, br_btaken_i, br_npc_i,
        output dispatch_v_i, dispatch_pc_i, ext_redirect_v_i, ext_npc_i,
        output cmd_ready_i,
        input  poison_o, cmd_v_o, cmd_npc_o, cmd_branch_o, cmd_taken_o,
        input  busy_o, mispredict_cnt_o
    );

    // Redirect generator side.
    modport slave (
        input  br_v_i, br_branch_i, br_btaken_i, br_npc_i,
        input  dispatch_v_i, dispatch_pc_i, ext_redirect_v_i, ext_npc_i,
        input  cmd_ready_i,
        output poison_o, cmd_v_o, cmd_npc_o, cmd_branch_o, cmd_taken_o,
        output busy_o, mispredict_cnt_o
    );
endinterface

// File: rtl/bp_be_redirect_gen.sv
// Backend redirect generator: tracks the expected next PC, poisons
// wrong-path dispatches and issues redirect commands to the frontend.
// Trap/CSR redirects override branch state; one newer trap redirect may be
// parked while a command is still waiting for the frontend to accept it.
module bp_be_redirect_gen #(
    parameter int                     vaddr_width_p = 39,
    parameter logic [vaddr_width_p-1:0] boot_pc_p   = 39'h0080000000,
    parameter int                     cnt_width_p   = 16
) (
    input logic                clk_i,
    input logic                reset_i,
    bp_be_redirect_gen_if.slave bus
);
    typedef enum logic [1:0] {RUN, SEND, WAIT} state_e;

    state_e                   state_r, state_n;
    logic [vaddr_width_p-1:0] npc_r, npc_n;
    logic                     br_branch_r, br_branch_n;
    logic                     br_taken_r, br_taken_n;
    logic                     pending_v_r, pending_v_n;
    logic [vaddr_width_p-1:0] pending_npc_r, pending_npc_n;
    logic [cnt_width_p-1:0]   cnt_r, cnt_n;
    logic [vaddr_width_p-1:0] expected;
    logic                     poison, cmd_v;

    // State register; reset drops everything back to the boot context at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= RUN;
            npc_r         <= boot_pc_p;
            br_branch_r   <= 1'b0;
            br_taken_r    <= 1'b0;
            pending_v_r   <= 1'b0;
            pending_npc_r <= '0;
            cnt_r         <= '0;
        end else begin
            state_r       <= state_n;
            npc_r         <= npc_n;
            br_branch_r   <= br_branch_n;
            br_taken_r    <= br_taken_n;
            pending_v_r   <= pending_v_n;
            pending_npc_r <= pending_npc_n;
            cnt_r         <= cnt_n;
        end
    end

    // Next-state, poison and command-valid decode.
    always_comb begin
        state_n       = state_r;
        npc_n         = npc_r;
        br_branch_n   = br_branch_r;
        br_taken_n    = br_taken_r;
        pending_v_n   = pending_v_r;
        pending_npc_n = pending_npc_r;
        cnt_n         = cnt_r;
        poison        = 1'b0;
        cmd_v         = 1'b0;
        // A resolution in the same cycle as the dispatch it predicts is bypassed.
        expected      = (bus.br_v_i && state_r == RUN) ? bus.br_npc_i : npc_r;

        case (state_r)
            RUN: begin
                if (bus.ext_redirect_v_i) begin
                    npc_n       = bus.ext_npc_i;
                    br_branch_n = 1'b0;
                    br_taken_n  = 1'b0;
                    poison      = bus.dispatch_v_i;
                    state_n     = SEND;
                end else begin
                    if (bus.br_v_i) begin
                        npc_n       = bus.br_npc_i;
                        br_branch_n = bus.br_branch_i;
                        br_taken_n  = bus.br_btaken_i;
                    end
                    if (bus.dispatch_v_i && bus.dispatch_pc_i != expected) begin
                        poison  = 1'b1;
                        npc_n   = expected;
                        state_n = SEND;
                        if (cnt_r != {cnt_width_p{1'b1}})
                            cnt_n = cnt_r + 1'b1;
                    end
                end
            end
            SEND: begin
                cmd_v  = 1'b1;
                poison = bus.dispatch_v_i;
                if (bus.cmd_ready_i) begin
                    // Command accepted: a trap redirect arriving now, or one
                    // parked earlier, becomes the next command immediately.
                    if (bus.ext_redirect_v_i) begin
                        npc_n       = bus.ext_npc_i;
                        br_branch_n = 1'b0;
                        br_taken_n  = 1'b0;
                        pending_v_n = 1'b0;
                    end else if (pending_v_r) begin
                        npc_n       = pending_npc_r;
                        br_branch_n = 1'b0;
                        br_taken_n  = 1'b0;
                        pending_v_n = 1'b0;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (bus.ext_redirect_v_i) begin
                    // Payload must hold until accepted; park the newer target.
                    pending_v_n   = 1'b1;
                    pending_npc_n = bus.ext_npc_i;
                end
            end
            WAIT: begin
                if (bus.ext_redirect_v_i) begin
                    npc_n       = bus.ext_npc_i;
                    br_branch_n = 1'b0;
                    br_taken_n  = 1'b0;
                    poison      = bus.dispatch_v_i;
                    state_n     = SEND;
                end else if (bus.dispatch_v_i) begin
                    if (bus.dispatch_pc_i == npc_r) state_n = RUN;
                    else                            poison  = 1'b1;
                end
            end
            default: state_n = RUN;
        endcase
    end

    assign bus.poison_o         = poison;
    assign bus.cmd_v_o          = cmd_v;
    assign bus.cmd_npc_o        = npc_r;
    assign bus.cmd_branch_o     = br_branch_r;
    assign bus.cmd_taken_o      = br_taken_r;
    assign bus.busy_o           = (state_r != RUN);
    assign bus.mispredict_cnt_o = cnt_r;
endmodule

// File: tb/tb_bp_be_redirect_gen.sv
// Directed bench for bp_be_redirect_gen. Two instances share the stimulus:
// one with the default counter width and one with a 4-bit counter for the
// saturation case. A queue-based model of outstanding redirect commands
// predicts outputs every cycle; literal checks pin the test-plan values.
module tb_bp_be_redirect_gen;
    localparam logic [38:0] BOOT = 39'h0080000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_v = 0, br_branch = 0, br_btaken = 0;
    logic [38:0] br_npc = '0;
    logic        dispatch_v = 0;
    logic [38:0] dispatch_pc = '0;
    logic        ext_v = 0;
    logic [38:0] ext_npc = '0;
    logic        ready = 0;

    int total = 0;
    int bad   = 0;

    bp_be_redirect_gen_if #(.vaddr_width_p(39), .cnt_width_p(16)) ifa ();
    bp_be_redirect_gen_if #(.vaddr_width_p(39), .cnt_width_p(4))  ifb ();

    assign ifa.br_v_i = br_v;           assign ifb.br_v_i = br_v;
    assign ifa.br_branch_i = br_branch; assign ifb.br_branch_i = br_branch;
    assign ifa.br_btaken_i = br_btaken; assign ifb.br_btaken_i = br_btaken;
    assign ifa.br_npc_i = br_npc;       assign ifb.br_npc_i = br_npc;
    assign ifa.dispatch_v_i = dispatch_v;   assign ifb.dispatch_v_i = dispatch_v;
    assign ifa.dispatch_pc_i = dispatch_pc; assign ifb.dispatch_pc_i = dispatch_pc;
    assign ifa.ext_redirect_v_i = ext_v; assign ifb.ext_redirect_v_i = ext_v;
    assign ifa.ext_npc_i = ext_npc;     assign ifb.ext_npc_i = ext_npc;
    assign ifa.cmd_ready_i = ready;     assign ifb.cmd_ready_i = ready;

    bp_be_redirect_gen #(.vaddr_width_p(39), .boot_pc_p(BOOT), .cnt_width_p(16)) dut_a (
        .clk_i(clk), .reset_i(rst), .bus(ifa));
    bp_be_redirect_gen #(.vaddr_width_p(39), .boot_pc_p(BOOT), .cnt_width_p(4)) dut_b (
        .clk_i(clk), .reset_i(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // cmdq[0] is the command on the bus; cmdq[1] a parked trap redirect.
    typedef struct {
        logic [38:0] npc;
        logic        br;
        logic        tk;
    } cmd_t;
    cmd_t        cmdq[$];
    logic [38:0] m_pc;
    logic        m_br, m_tk, m_waiting;
    int          m_cnt;

    always @(negedge clk) begin
        logic        sending, busy, e_poison;
        logic [38:0] expect_pc;
        cmd_t        c;
        if (rst) begin
            cmdq.delete();
            m_pc = BOOT; m_br = 0; m_tk = 0; m_waiting = 0; m_cnt = 0;
        end
        sending   = (cmdq.size() != 0);
        busy      = sending || m_waiting;
        expect_pc = (!busy && br_v) ? br_npc : m_pc;
        e_poison  = dispatch_v && (ext_v || sending ||
                    (m_waiting && dispatch_pc != m_pc) ||
                    (!busy && dispatch_pc != expect_pc));

        chk("poison", ifa.poison_o, e_poison);
        chk("poison_b", ifb.poison_o, e_poison);
        chk("cmd_v", ifa.cmd_v_o, sending);
        chk("busy", ifa.busy_o, busy);
        chk("cnt16", ifa.mispredict_cnt_o, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("cnt4", ifb.mispredict_cnt_o, (m_cnt > 15) ? 15 : m_cnt);
        if (sending) begin
            chk("cmd_npc", ifa.cmd_npc_o, cmdq[0].npc);
            chk("cmd_branch", ifa.cmd_branch_o, cmdq[0].br);
            chk("cmd_taken", ifa.cmd_taken_o, cmdq[0].tk);
        end else if (rst) begin
            chk("rst_npc", ifa.cmd_npc_o, BOOT);
            chk("rst_branch", ifa.cmd_branch_o, 1'b0);
            chk("rst_taken", ifa.cmd_taken_o, 1'b0);
        end

        if (!rst) begin
            if (ext_v) begin
                if (sending) begin
                    if (ready) cmdq.delete();
                    else if (cmdq.size() > 1) void'(cmdq.pop_back());
                end
                c.npc = ext_npc; c.br = 0; c.tk = 0;
                cmdq.push_back(c);
                m_pc = ext_npc; m_br = 0; m_tk = 0; m_waiting = 0;
            end else if (sending) begin
                if (ready) begin
                    void'(cmdq.pop_front());
                    if (cmdq.size() == 0) m_waiting = 1;
                    else begin m_br = 0; m_tk = 0; end
                end
            end else if (m_waiting) begin
                if (dispatch_v && dispatch_pc == m_pc) m_waiting = 0;
            end else begin
                if (br_v) begin m_pc = br_npc; m_br = br_branch; m_tk = br_btaken; end
                if (dispatch_v && dispatch_pc != expect_pc) begin
                    m_pc = expect_pc;
                    c.npc = expect_pc; c.br = m_br; c.tk = m_tk;
                    cmdq.push_back(c);
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        br_v = 0; br_branch = 0; br_btaken = 0; br_npc = '0;
        dispatch_v = 0; dispatch_pc = '0; ext_v = 0; ext_npc = '0; ready = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_npc", ifa.cmd_npc_o, BOOT);
        chk("lit_rst_cmdv", ifa.cmd_v_o, 1'b0);
        rst = 0;
        tick();

        // sequential stream
        br_v = 1; br_npc = 39'h1004;
        tick();
        dispatch_v = 1; dispatch_pc = 39'h1004;
        #1 chk("lit_seq_poison", ifa.poison_o, 1'b0);
        tick();
        chk("lit_seq_cmdv", ifa.cmd_v_o, 1'b0);
        chk("lit_seq_cnt", ifa.mispredict_cnt_o, 16'd0);

        // taken branch with same-cycle wrong-path dispatch
        br_v = 1; br_branch = 1; br_btaken = 1; br_npc = 39'h2000;
        dispatch_v = 1; dispatch_pc = 39'h1008;
        #1 chk("lit_tk_poison", ifa.poison_o, 1'b1);
        tick();
        chk("lit_tk_cmdv", ifa.cmd_v_o, 1'b1);
        chk("lit_tk_npc", ifa.cmd_npc_o, 39'h2000);
        chk("lit_tk_branch", ifa.cmd_branch_o, 1'b1);
        chk("lit_tk_taken", ifa.cmd_taken_o, 1'b1);
        chk("lit_tk_cnt", ifa.mispredict_cnt_o, 16'd1);

        // backpressure
        for (int i = 0; i < 5; i++) begin
            dispatch_v = 1; dispatch_pc = 39'h2000 + 39'(i * 4);
            br_v = 1; br_npc = 39'h7000;
            tick();
        end
        chk("lit_bp_npc", ifa.cmd_npc_o, 39'h2000);
        ready = 1;
        tick();
        chk("lit_wait_busy", ifa.busy_o, 1'b1);
        dispatch_v = 1; dispatch_pc = 39'h1234;
        #1 chk("lit_wait_poison", ifa.poison_o, 1'b1);
        tick();
        dispatch_v = 1; dispatch_pc = 39'h2000;
        #1 chk("lit_wait_accept", ifa.poison_o, 1'b0);
        tick();
        chk("lit_run_busy", ifa.busy_o, 1'b0);

        // external redirect while a command is stalled
        dispatch_v = 1; dispatch_pc = 39'h2004;
        tick();
        ext_v = 1; ext_npc = 39'h3000;
        tick();
        chk("lit_ext_hold", ifa.cmd_npc_o, 39'h2000);
        ready = 1;
        tick();
        chk("lit_ext_cmdv", ifa.cmd_v_o, 1'b1);
        chk("lit_ext_npc", ifa.cmd_npc_o, 39'h3000);
        chk("lit_ext_branch", ifa.cmd_branch_o, 1'b0);
        ready = 1;
        tick();
        dispatch_v = 1; dispatch_pc = 39'h3000;
        tick();
        chk("lit_ext_cnt", ifa.mispredict_cnt_o, 16'd2);

        // external redirect in RUN with a same-cycle dispatch, then in WAIT
        ext_v = 1; ext_npc = 39'h6000; dispatch_v = 1; dispatch_pc = 39'h3000;
        #1 chk("lit_extrun_poison", ifa.poison_o, 1'b1);
        tick();
        ready = 1;
        tick();
        ext_v = 1; ext_npc = 39'h6100;
        tick();
        ready = 1;
        tick();
        dispatch_v = 1; dispatch_pc = 39'h6100;
        tick();
        chk("lit_extrun_cnt", ifa.mispredict_cnt_o, 16'd2);

        // counter saturation
        for (int i = 0; i < 17; i++) begin
            br_v = 1; br_npc = 39'h4000 + 39'(i * 16);
            dispatch_v = 1; dispatch_pc = 39'h4004 + 39'(i * 16);
            tick();
            ready = 1;
            tick();
            dispatch_v = 1; dispatch_pc = 39'h4000 + 39'(i * 16);
            tick();
        end
        chk("lit_sat4", ifb.mispredict_cnt_o, 4'hF);
        chk("lit_cnt16", ifa.mispredict_cnt_o, 16'd19);

        // reset asserted while sending
        dispatch_v = 1; dispatch_pc = 39'h5555;
        tick();
        chk("lit_pre_rst_cmdv", ifa.cmd_v_o, 1'b1);
        rst = 1;
        #1;
        chk("lit_rst_cmdv_async", ifa.cmd_v_o, 1'b0);
        chk("lit_rst_busy_async", ifa.busy_o, 1'b0);
        dispatch_v = 1; dispatch_pc = BOOT;
        #1 chk("lit_rst_poison", ifa.poison_o, 1'b0);
        tick();
        rst = 0;
        tick();
        dispatch_v = 1; dispatch_pc = BOOT;
        #1 chk("lit_boot_poison", ifa.poison_o, 1'b0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
